dbus_uart_tx: RTL

Memory-mapped UART transmitter that sits as a responder on the CPU data bus (Dw* signals) in the Core peripheral space. The CPU writes bytes into a transmit FIFO and reads status and baud settings through word-aligned registers. A serializer FSM drains the FIFO onto a single 8N1 serial line.

---
 rtl/dbus_uart_tx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus: TX FIFO, status/baud registers, serializer.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module dbus_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'hFF20_0100,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        DwReadEnable,
    input  logic        DwWriteEnable,
    input  logic [3:0]  DwByteEnable,
    input  logic [31:0] DwAddress,
    input  logic [31:0] DwWriteData,
    output logic [31:0] DwReadData,
    output logic        oTX,
    output logic        oBusy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        baud_q, baud_d;
    logic [15:0]        tmr_q, tmr_d;
    logic [15:0]        div_q, div_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_q, par_d;
    logic [7:0]         fifo_mem_q [FIFO_DEPTH];

    logic        sel, full, empty, push, pop, wr_tx, rd_status, tick_end, tx;
    logic [1:0]  offs;
    logic [15:0] eff_div;
    logic [7:0]  head;
    logic        unused_bits;

    assign unused_bits = ^{DwAddress[1:0], DwWriteData[31:16], DwByteEnable[3:2]};

    assign sel       = (DwAddress[31:4] == BASE_ADDR[31:4]);
    assign offs      = DwAddress[3:2];
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign wr_tx     = sel && DwWriteEnable && (offs == 2'd0) && DwByteEnable[0];
    assign push      = wr_tx && !full;
    assign rd_status = sel && DwReadEnable && (offs == 2'd1);
    assign eff_div   = (baud_q == 16'd0) ? 16'd1 : baud_q;
    assign head      = fifo_mem_q[rd_ptr_q];
    assign tick_end  = (tmr_q == 16'd0);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A dropped push wins over the clear from a concurrent STATUS read.
        ovf_d = (wr_tx && full) ? 1'b1 : (rd_status ? 1'b0 : ovf_q);
        baud_d = baud_q;
        if (sel && DwWriteEnable && (offs == 2'd2)) begin
            if (DwByteEnable[0]) baud_d[7:0]  = DwWriteData[7:0];
            if (DwByteEnable[1]) baud_d[15:8] = DwWriteData[15:8];
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tick_end ? div_q - 16'd1 : tmr_q - 16'd1;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        tx      = 1'b1;
        case (state_q)
            S_IDLE: begin
                tmr_d = tmr_q;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = ^head;
                    div_d   = eff_div;
                    tmr_d   = eff_div - 16'd1;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (tick_end) state_d = S_DATA;
            end
            S_DATA: begin
                tx = shift_q[0];
                if (tick_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx = par_q;
                if (tick_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                tx = 1'b1;
                if (tick_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            baud_q   <= DEFAULT_DIV;
            tmr_q    <= '0;
            bit_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            baud_q   <= baud_d;
            tmr_q    <= tmr_d;
            bit_q    <= bit_d;
        end
    end

    // Datapath storage carries no reset; it is always reloaded before use.
    always_ff @(posedge iCLK) begin
        shift_q <= shift_d;
        div_q   <= div_d;
        par_q   <= par_d;
        if (push) fifo_mem_q[wr_ptr_q] <= DwWriteData[7:0];
    end

    assign oTX   = tx;
    assign oBusy = (state_q != S_IDLE) || !empty;

    always_comb begin
        DwReadData = 32'h0;
        if (sel && DwReadEnable) begin
            case (offs)
                2'd1:    DwReadData = {16'h0, 8'(count_q), 4'h0, ovf_q, empty, full, oBusy};
                2'd2:    DwReadData = {16'h0, baud_q};
                default: DwReadData = 32'h0;
            endcase
        end
    end
endmodule
